muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have port: clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: req_mult  in  1  start-multiply request from the control unit; sampled only in IDLE.
REQ-004 SHALL have port: req_div  in  1  start-divide request from the control unit; sampled only in IDLE.
REQ-005 SHALL have port: mult_start  out  1  one-cycle start pulse to the multiplier.
REQ-006 SHALL have port: div_start  out  1  one-cycle start pulse to the divider.
REQ-007 SHALL have port: mult_end  in  1  multiplier completion; HI/LO results stay stable until the next mult_start.
REQ-008 SHALL have port: div_end  in  1  divider completion; HI/LO results stay stable until the next div_start.
REQ-009 SHALL have port: div_zero  in  1  divider divide-by-zero flag; valid while in DWAIT.
REQ-010 SHALL have port: hilo_sel  out  1  HI/LO source select: 0 = multiplier, 1 = divider.
REQ-011 SHALL have port: hilo_write  out  1  HI and LO register load enable.
REQ-012 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-013 SHALL have port: done  out  1  one-cycle pulse when a result is committed.
REQ-014 SHALL have port: div_zero_exc  out  1  one-cycle exception pulse to the control unit.
REQ-015 SHALL have port: timeout_err  out  1  one-cycle watchdog error pulse.

Function
REQ-016 SHALL implement a registered FSM with these states: IDLE, MSTART, MWAIT, DSTART, DWAIT, WRITE, EXC, TOUT.
REQ-017 In IDLE, req_mult=1 SHALL move the FSM to MSTART; otherwise req_div=1 SHALL move it to DSTART.
REQ-018 If req_mult and req_div are both 1 in IDLE, the multiply SHALL win and the divide SHALL be dropped, not queued.
REQ-019 Requests arriving in any state other than IDLE SHALL be ignored.
REQ-020 mult_start SHALL be 1 only in MSTART; MSTART SHALL last one cycle and then go to MWAIT.
REQ-021 div_start SHALL be 1 only in DSTART; DSTART SHALL last one cycle and then go to DWAIT.
REQ-022 Start latency: a request sampled at edge N SHALL produce the start pulse in the cycle following edge N.
REQ-023 MWAIT SHALL go to WRITE on the edge where mult_end=1.
REQ-024 DWAIT with div_zero=1 SHALL go to EXC, taking priority over div_end.
REQ-025 DWAIT with div_end=1 and div_zero=0 SHALL go to WRITE.
REQ-026 WRITE SHALL assert hilo_write=1 and done=1 for exactly one cycle and then return to IDLE.
REQ-027 EXC SHALL assert div_zero_exc=1 for one cycle with hilo_write=0 and then return to IDLE; HI/LO are left unchanged.
REQ-028 hilo_sel SHALL be a register: cleared to 0 on entry to MSTART, set to 1 on entry to DSTART, and otherwise held.
REQ-029 hilo_sel SHALL be stable from the start pulse through WRITE.
REQ-030 mult_end, div_end and div_zero SHALL be ignored in IDLE, MSTART and DSTART; stale completions must not cause a write.
REQ-031 mult_end SHALL be ignored in DWAIT, and div_end in MWAIT.
REQ-032 All outputs SHALL be driven from state or registers, never combinationally from inputs.

Reset
REQ-033 rst=0 SHALL force, asynchronously and regardless of the clock: state=IDLE, hilo_sel=0, all other outputs 0, and the watchdog counter to 0.
REQ-034 Reset asserted mid-operation SHALL abandon the operation with no hilo_write, done or exception pulse.
REQ-035 The first request SHALL be accepted on the first rising edge after rst returns high.

Configuration
REQ-036 Macro MULDIV_TIMEOUT_EN SHALL compile the watchdog in or out.
REQ-037 With MULDIV_TIMEOUT_EN defined, a 6-bit counter SHALL clear on the start pulse and increment each cycle spent in MWAIT or DWAIT.
REQ-038 With MULDIV_TIMEOUT_EN defined, a count of 63 with no completion SHALL move the FSM to TOUT, which asserts timeout_err for one cycle with hilo_write=0 and then returns to IDLE.
REQ-039 With MULDIV_TIMEOUT_EN defined, a completion arriving in the same cycle the count reaches 63 SHALL win over the timeout.
REQ-040 Without MULDIV_TIMEOUT_EN, the counter and the TOUT state SHALL be absent, timeout_err SHALL be tied to 0, and the WAIT states SHALL wait indefinitely.

Verification
REQ-041 Multiply: req_mult pulse at cycle 0 -> mult_start=1 in cycle 1; mult_end=1 in cycle 34 -> cycle 35 shows hilo_write=1, done=1, hilo_sel=0; busy falls in cycle 36.
REQ-042 Divide: req_div pulse -> div_start one cycle later; div_end after 32 cycles -> hilo_write=1 with hilo_sel=1.
REQ-043 Divide by zero: in DWAIT, div_zero=1 and div_end=1 in the same cycle -> div_zero_exc=1 for one cycle, hilo_write never asserted, FSM returns to IDLE.
REQ-044 Collision: req_mult=1 and req_div=1 in the same IDLE cycle -> only mult_start pulses; a req_div pulse while busy produces no div_start.
REQ-045 Reset mid-op: rst=0 for 2 cycles during MWAIT -> all outputs 0 immediately; a later mult_end=1 in IDLE -> no hilo_write.
REQ-046 Timeout (MULDIV_TIMEOUT_EN defined): no mult_end after mult_start -> timeout_err=1 exactly 64 cycles after MWAIT entry, then busy=0; without the macro, busy stays 1.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Purpose:
//   Control FSM that sits between the control unit and an iterative
//   multiplier / divider pair. It issues one-cycle start pulses, waits for the
//   selected unit to complete, and then either commits the result into HI/LO
//   or raises a divide-by-zero exception. An optional watchdog aborts a unit
//   that never completes.
//
// Configuration:
//   MULDIV_TIMEOUT_EN  - when defined, a 6-bit watchdog counter and the TOUT
//                        state are built in. When undefined, timeout_err is
//                        tied low and the WAIT states wait indefinitely.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active low
//   req_mult     in   start-multiply request (honoured only in IDLE)
//   req_div      in   start-divide request (honoured only in IDLE)
//   mult_start   out  one-cycle start pulse to the multiplier
//   div_start    out  one-cycle start pulse to the divider
//   mult_end     in   multiplier completion
//   div_end      in   divider completion
//   div_zero     in   divider divide-by-zero flag (looked at only in DWAIT)
//   hilo_sel     out  HI/LO source select: 0 = multiplier, 1 = divider
//   hilo_write   out  HI/LO load enable
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse when a result is committed
//   div_zero_exc out  one-cycle divide-by-zero exception pulse
//   timeout_err  out  one-cycle watchdog error pulse
// -----------------------------------------------------------------------------
module muldiv_sequencer (
  input  logic clk,
  input  logic rst,
  input  logic req_mult,
  input  logic req_div,
  output logic mult_start,
  output logic div_start,
  input  logic mult_end,
  input  logic div_end,
  input  logic div_zero,
  output logic hilo_sel,
  output logic hilo_write,
  output logic busy,
  output logic done,
  output logic div_zero_exc,
  output logic timeout_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MSTART = 3'd1,
    MWAIT  = 3'd2,
    DSTART = 3'd3,
    DWAIT  = 3'd4,
    WRITE  = 3'd5,
    EXC    = 3'd6
`ifdef MULDIV_TIMEOUT_EN
    ,
    TOUT   = 3'd7
`endif
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   r_hilo_sel;

`ifdef MULDIV_TIMEOUT_EN
  logic [5:0] r_wdog_cnt;
  logic       w_wdog_expired;

  assign w_wdog_expired = (r_wdog_cnt == 6'd63);
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. Completion inputs are only looked at in the WAIT state
  // of the unit that was started, so stale or cross-unit completions are
  // harmless. A completion beats the watchdog when both occur together.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_mult) begin
          w_state_next = MSTART;
        end else if (req_div) begin
          w_state_next = DSTART;
        end
      end
      MSTART: w_state_next = MWAIT;
      MWAIT: begin
        if (mult_end) begin
          w_state_next = WRITE;
        end
`ifdef MULDIV_TIMEOUT_EN
        else if (w_wdog_expired) begin
          w_state_next = TOUT;
        end
`endif
      end
      DSTART: w_state_next = DWAIT;
      DWAIT: begin
        // Divide-by-zero takes priority over a simultaneous div_end.
        if (div_zero) begin
          w_state_next = EXC;
        end else if (div_end) begin
          w_state_next = WRITE;
        end
`ifdef MULDIV_TIMEOUT_EN
        else if (w_wdog_expired) begin
          w_state_next = TOUT;
        end
`endif
      end
      WRITE:   w_state_next = IDLE;
      EXC:     w_state_next = IDLE;
`ifdef MULDIV_TIMEOUT_EN
      TOUT:    w_state_next = IDLE;
`endif
      default: w_state_next = IDLE;
    endcase
  end

  // HI/LO source select: updated only when a new operation is launched, so it
  // holds steady from the start pulse through the commit cycle and beyond.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hilo_sel <= 1'b0;
    end else if (w_state_next == MSTART) begin
      r_hilo_sel <= 1'b0;
    end else if (w_state_next == DSTART) begin
      r_hilo_sel <= 1'b1;
    end
  end

`ifdef MULDIV_TIMEOUT_EN
  // Watchdog: zeroed during the start pulse, counts every WAIT cycle. Wrap
  // after 63 is irrelevant because the FSM leaves the WAIT state on that edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog_cnt <= 6'd0;
    end else if ((r_state == MSTART) || (r_state == DSTART)) begin
      r_wdog_cnt <= 6'd0;
    end else if ((r_state == MWAIT) || (r_state == DWAIT)) begin
      r_wdog_cnt <= r_wdog_cnt + 6'd1;
    end
  end

  assign timeout_err = (r_state == TOUT);
`else
  assign timeout_err = 1'b0;
`endif

  // Moore outputs, decoded purely from registered state.
  assign mult_start   = (r_state == MSTART);
  assign div_start    = (r_state == DSTART);
  assign hilo_write   = (r_state == WRITE);
  assign done         = (r_state == WRITE);
  assign div_zero_exc = (r_state == EXC);
  assign busy         = (r_state != IDLE);
  assign hilo_sel     = r_hilo_sel;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Directed bench for muldiv_sequencer. Inputs change and outputs are sampled
// on the falling clock edge; a "cycle" is the interval between rising edges.
// All outputs are packed into one 8-bit vector so each check covers the full
// output state:
//   [7] busy [6] done [5] hilo_write [4] hilo_sel
//   [3] mult_start [2] div_start [1] div_zero_exc [0] timeout_err
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

  logic clk;
  logic rst;
  logic req_mult;
  logic req_div;
  logic mult_start;
  logic div_start;
  logic mult_end;
  logic div_end;
  logic div_zero;
  logic hilo_sel;
  logic hilo_write;
  logic busy;
  logic done;
  logic div_zero_exc;
  logic timeout_err;

  int errors = 0;
  int checks = 0;

  localparam logic [7:0] O_IDLE_M = 8'b0000_0000;
  localparam logic [7:0] O_IDLE_D = 8'b0001_0000;
  localparam logic [7:0] O_MSTART = 8'b1000_1000;
  localparam logic [7:0] O_MWAIT  = 8'b1000_0000;
  localparam logic [7:0] O_DSTART = 8'b1001_0100;
  localparam logic [7:0] O_DWAIT  = 8'b1001_0000;
  localparam logic [7:0] O_WRITEM = 8'b1110_0000;
  localparam logic [7:0] O_WRITED = 8'b1111_0000;
  localparam logic [7:0] O_EXC    = 8'b1001_0010;
  localparam logic [7:0] O_TOUT   = 8'b1000_0001;

  logic [7:0] outs;
  assign outs = {busy, done, hilo_write, hilo_sel,
                 mult_start, div_start, div_zero_exc, timeout_err};

  muldiv_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .req_mult     (req_mult),
    .req_div      (req_div),
    .mult_start   (mult_start),
    .div_start    (div_start),
    .mult_end     (mult_end),
    .div_end      (div_end),
    .div_zero     (div_zero),
    .hilo_sel     (hilo_sel),
    .hilo_write   (hilo_write),
    .busy         (busy),
    .done         (done),
    .div_zero_exc (div_zero_exc),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic [7:0] exp);
    check_value(tag, {24'd0, outs}, {24'd0, exp});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int c;
    int found;

    rst      = 1'b0;
    req_mult = 1'b0;
    req_div  = 1'b0;
    mult_end = 1'b0;
    div_end  = 1'b0;
    div_zero = 1'b0;

    // ---- reset state ----
    tick();
    expect_outs("reset_state", O_IDLE_M);
    $display("txn reset at %0t", $time);

    // ---- multiply: request in cycle 0, mult_end in cycle 34 ----
    rst      = 1'b1;
    req_mult = 1'b1;                     // cycle 0
    tick();                              // cycle 1
    expect_outs("mult_c1_start", O_MSTART);
    req_mult = 1'b0;
    c = 1;
    while (c < 34) begin
      tick();
      c++;
      if (c == 2 || c == 20) expect_outs("mult_wait", O_MWAIT);
    end
    mult_end = 1'b1;                     // cycle 34
    tick();                              // cycle 35
    expect_outs("mult_c35_write", O_WRITEM);
    mult_end = 1'b0;
    tick();                              // cycle 36
    expect_outs("mult_c36_idle", O_IDLE_M);
    $display("txn multiply at %0t", $time);

    // ---- divide with stale / cross-unit inputs ----
    req_div = 1'b1;
    tick();                              // DSTART
    expect_outs("div_start", O_DSTART);
    req_div = 1'b0;
    div_end = 1'b1;                      // stale: sampled leaving DSTART
    tick();                              // DWAIT
    expect_outs("div_stale_end", O_DWAIT);
    div_end  = 1'b0;
    mult_end = 1'b1;                     // wrong unit
    req_mult = 1'b1;                     // busy: ignored
    tick();
    expect_outs("div_ignore_mend", O_DWAIT);
    mult_end = 1'b0;
    req_mult = 1'b0;
    c = 3;
    while (c < 33) begin
      tick();
      c++;
    end
    div_end = 1'b1;
    tick();
    expect_outs("div_write", O_WRITED);
    div_end = 1'b0;
    tick();
    expect_outs("div_idle_sel_held", O_IDLE_D);
    $display("txn divide at %0t", $time);

    // ---- divide by zero, div_end in the same cycle ----
    req_div = 1'b1;
    tick();
    expect_outs("dz_start", O_DSTART);
    req_div = 1'b0;
    tick();
    expect_outs("dz_wait", O_DWAIT);
    div_zero = 1'b1;
    div_end  = 1'b1;
    tick();
    expect_outs("dz_exc", O_EXC);
    div_zero = 1'b0;
    div_end  = 1'b0;
    tick();
    expect_outs("dz_idle", O_IDLE_D);
    $display("txn divzero at %0t", $time);

    // ---- collision: multiply wins, divide dropped ----
    req_mult = 1'b1;
    req_div  = 1'b1;
    tick();
    expect_outs("col_mstart", O_MSTART);
    req_mult = 1'b0;
    req_div  = 1'b0;
    tick();
    expect_outs("col_mwait", O_MWAIT);
    req_div = 1'b1;                      // busy: no div_start
    div_end = 1'b1;                      // wrong unit: no write
    tick();
    expect_outs("col_busy_req", O_MWAIT);
    req_div  = 1'b0;
    div_end  = 1'b0;
    mult_end = 1'b1;
    tick();
    expect_outs("col_write", O_WRITEM);
    mult_end = 1'b0;
    tick();
    expect_outs("col_idle_nodiv", O_IDLE_M);
    $display("txn collision at %0t", $time);

    // ---- reset mid-operation during MWAIT ----
    req_div = 1'b1;                      // set hilo_sel to 1 first
    tick();
    req_div = 1'b0;
    tick();
    div_zero = 1'b1;
    tick();
    div_zero = 1'b0;
    tick();
    expect_outs("rst_pre_idle", O_IDLE_D);
    req_mult = 1'b1;
    tick();
    req_mult = 1'b0;
    tick();
    tick();
    expect_outs("rst_pre_mwait", O_MWAIT);
    #2 rst = 1'b0;
    #1 expect_outs("rst_async", O_IDLE_M);
    tick();
    tick();
    rst      = 1'b1;
    mult_end = 1'b1;                     // stale completion in IDLE
    tick();
    expect_outs("rst_stale_end", O_IDLE_M);
    mult_end = 1'b0;
    $display("txn reset_midop at %0t", $time);

    // ---- watchdog ----
    req_mult = 1'b1;
    tick();                              // cycle 1: MSTART
    req_mult = 1'b0;
    expect_outs("wd_mstart", O_MSTART);
`ifdef MULDIV_TIMEOUT_EN
    // Completion exactly when count reaches 63 (cycle 65) must win.
    c = 1;
    while (c < 65) begin
      tick();
      c++;
    end
    mult_end = 1'b1;
    tick();
    expect_outs("wd_race_write", O_WRITEM);
    mult_end = 1'b0;
    tick();
    req_mult = 1'b1;
    tick();                              // cycle 1: MSTART
    req_mult = 1'b0;
    c = 1;
    found = -1;
    while (c < 100 && found < 0) begin
      tick();
      c++;
      if (timeout_err) found = c;
    end
    check_value("wd_tout_cycle", found, 66);   // 64 cycles after MWAIT entry
    expect_outs("wd_tout_outs", O_TOUT);
    if (found < 0) mult_end = 1'b1;      // recover from a stuck wait
    tick();
    mult_end = 1'b0;
    expect_outs("wd_after_tout", O_IDLE_M);
`else
    c = 1;
    found = 0;
    while (c < 80) begin
      tick();
      c++;
      if (timeout_err || !busy) found++;
    end
    check_value("wd_no_tout", found, 0);
    expect_outs("wd_still_busy", O_MWAIT);
    mult_end = 1'b1;
    tick();
    expect_outs("wd_late_write", O_WRITEM);
    mult_end = 1'b0;
    tick();
    expect_outs("wd_idle", O_IDLE_M);
`endif
    $display("txn watchdog at %0t", $time);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
